// File: rtl/mem_store_tracer.sv
// rtl/mem_store_tracer.sv - processor store-event tracer with capture FIFO
//
// Captures {MemAddr_IO, MemD_IO} on each rising edge of MemRW_IO (while
// trace_en=1) into a DEPTH-entry FIFO and presents the oldest entry.
// Optional macro: STORE_TRACE_DROP_CNT_EN enables the saturating drop counter.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   MemRW_IO          processor bus direction (1 = store)
//   MemAddr_IO        processor bus address
//   MemD_IO           processor bus store data
//   trace_en          capture enable, sampled at event detection
//   clear             synchronous flush of FIFO and flags
//   out_valid/ready   head entry handshake
//   out_addr/data     head entry contents
//   count             current occupancy
//   overflow          sticky: at least one store dropped
//   drop_cnt          dropped-store count (0 when the counter is not built)
module mem_store_tracer #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     MemRW_IO,
   input  logic [ADDR_W-1:0]        MemAddr_IO,
   input  logic [DATA_W-1:0]        MemD_IO,
   input  logic                     trace_en,
   input  logic                     clear,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ADDR_W-1:0]        out_addr,
   output logic [DATA_W-1:0]        out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [7:0]               drop_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = ADDR_W + DATA_W;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic              rw_q;
   logic              armed_q;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              ovf_q, ovf_d;
   logic [EW-1:0]     mem_q [DEPTH];

   logic evt, full, empty, pop, push, drop;

   always_comb begin
      // armed_q blocks the first cycle after reset release, so a store already
      // high at release is not mistaken for a rising edge.
      evt   = MemRW_IO & ~rw_q & trace_en & armed_q;
      full  = (count_q == FULL);
      empty = (count_q == '0);
      pop   = ~empty & out_ready;
      push  = evt & (~full | pop);
      drop  = evt & full & ~pop;

      wr_ptr_d   = wr_ptr_q + PW'(push);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      count_d    = count_q + CW'(push) - CW'(pop);
      ovf_d      = ovf_q | drop;
      out_addr_d = out_addr_q;
      out_data_d = out_data_q;

      // Registered head: when the new entry itself becomes the head (FIFO
      // empty after this edge's pop), take it from the bus, else from storage.
      if (count_d != '0) begin
         if (push && (rd_ptr_d == wr_ptr_q)) begin
            out_addr_d = MemAddr_IO;
            out_data_d = MemD_IO;
         end else begin
            {out_addr_d, out_data_d} = mem_q[rd_ptr_d];
         end
      end

      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rw_q       <= 1'b0;
         armed_q    <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         out_addr_q <= '0;
         out_data_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         rw_q       <= MemRW_IO;
         armed_q    <= 1'b1;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         out_addr_q <= out_addr_d;
         out_data_q <= out_data_d;
         ovf_q      <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem_q[wr_ptr_q] <= {MemAddr_IO, MemD_IO};
      end
   end

`ifdef STORE_TRACE_DROP_CNT_EN
   logic [7:0] drop_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_q <= 8'd0;
      end else if (clear) begin
         drop_q <= 8'd0;
      end else if (drop && (drop_q != 8'hFF)) begin
         drop_q <= drop_q + 8'd1;
      end
   end

   assign drop_cnt = drop_q;
`else
   assign drop_cnt = 8'd0;
`endif

   assign out_valid = ~empty;
   assign out_addr  = out_addr_q;
   assign out_data  = out_data_q;
   assign count     = count_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_mem_store_tracer.sv
// tb/tb_mem_store_tracer.sv - self-checking bench for mem_store_tracer
module tb_mem_store_tracer;

   localparam int DEPTH = 8;
   localparam int AW    = 8;
   localparam int DW    = 16;
`ifdef STORE_TRACE_DROP_CNT_EN
   localparam logic [7:0] EXP_DROP = 8'd2;
`else
   localparam logic [7:0] EXP_DROP = 8'd0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          MemRW_IO;
   logic [AW-1:0] MemAddr_IO;
   logic [DW-1:0] MemD_IO;
   logic          trace_en;
   logic          clear;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_data;
   logic [3:0]    count;
   logic          overflow;
   logic [7:0]    drop_cnt;

   int total = 0;
   int bad   = 0;
   logic [AW+DW-1:0] sb[$];

   always #5 clk = ~clk;

   mem_store_tracer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .MemRW_IO(MemRW_IO), .MemAddr_IO(MemAddr_IO),
      .MemD_IO(MemD_IO), .trace_en(trace_en), .clear(clear),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_data(out_data), .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; MemRW_IO = 1'b0; clear = 1'b0; out_ready = 1'b0; trace_en = 1'b1;
      MemAddr_IO = '0; MemD_IO = '0;
      step(); step();
      rst = 1'b1;
      step();
      sb.delete();
   endtask

   task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit keep);
      MemAddr_IO = a; MemD_IO = d; MemRW_IO = 1'b1;
      if (keep) sb.push_back({a, d});
      step();
      MemRW_IO = 1'b0;
      step();
   endtask

   task automatic drain(input string name);
      int budget = 40;
      logic [AW+DW-1:0] exp;
      out_ready = 1'b1;
      while ((sb.size() != 0 || out_valid) && budget > 0) begin
         if (out_valid) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL %s: unexpected entry addr=%h data=%h, none expected", name, out_addr, out_data);
            end else begin
               exp = sb.pop_front();
               if ({out_addr, out_data} !== exp) begin
                  bad++;
                  $display("FAIL %s: head got %h/%h expected %h/%h", name, out_addr, out_data, exp[AW+DW-1:DW], exp[DW-1:0]);
               end
            end
         end
         step();
         budget--;
      end
      out_ready = 1'b0;
      total++;
      if (budget == 0) begin bad++; $display("FAIL %s: drain timeout, %0d entries left", name, sb.size()); end
   endtask

   task automatic test_reset();
      rst = 1'b0; MemRW_IO = 1'b0; clear = 1'b0; out_ready = 1'b0; trace_en = 1'b0;
      MemAddr_IO = '0; MemD_IO = '0;
      step(); step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
      total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", count); end
      total++; if ({out_addr, out_data} !== '0) begin bad++; $display("FAIL reset_head: got %h/%h expected 0/0", out_addr, out_data); end
      total++; if ({overflow, drop_cnt} !== 9'd0) begin bad++; $display("FAIL reset_flags: got ovf=%b drop=%0d expected 0/0", overflow, drop_cnt); end
   endtask

   task automatic test_single_store();
      do_reset();
      MemAddr_IO = 8'h0D; MemD_IO = 16'h0042; MemRW_IO = 1'b1;
      sb.push_back({8'h0D, 16'h0042});
      step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_latency: out_valid got %b expected 1", out_valid); end
      total++; if ({out_addr, out_data} !== {8'h0D, 16'h0042}) begin bad++; $display("FAIL single_head: got %h/%h expected 0d/0042", out_addr, out_data); end
      step(); step();
      MemRW_IO = 1'b0;
      step();
      total++; if (count !== 4'd1) begin bad++; $display("FAIL single_hold: count got %0d expected 1", count); end
      drain("single_drain");
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 10; i++) store(AW'(8'h10 + i), DW'(16'h1000 + i * 3), i < DEPTH);
      total++; if (count !== 4'd8) begin bad++; $display("FAIL ovf_count: got %0d expected 8", count); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
      total++; if (drop_cnt !== EXP_DROP) begin bad++; $display("FAIL ovf_drop: got %0d expected %0d", drop_cnt, EXP_DROP); end
      drain("ovf_drain");
   endtask

   task automatic test_full_push_pop();
      logic [AW+DW-1:0] exp;
      do_reset();
      for (int i = 0; i < DEPTH; i++) store(AW'(8'h20 + i), DW'(16'h2000 + i), 1'b1);
      MemAddr_IO = 8'hA5; MemD_IO = 16'hBEEF; MemRW_IO = 1'b1; out_ready = 1'b1;
      exp = sb.pop_front();
      total++; if ({out_addr, out_data} !== exp) begin bad++; $display("FAIL full_pp_head: got %h/%h expected %h", out_addr, out_data, exp); end
      sb.push_back({8'hA5, 16'hBEEF});
      step();
      MemRW_IO = 1'b0; out_ready = 1'b0;
      total++; if (count !== 4'd8) begin bad++; $display("FAIL full_pp_count: got %0d expected 8", count); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_pp_ovf: got %b expected 0", overflow); end
      step();
      drain("full_pp_drain");
   endtask

   task automatic test_wrap();
      int max_cnt = 0;
      logic [AW+DW-1:0] exp;
      logic [DW-1:0] d;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         d = DW'($urandom);
         MemAddr_IO = AW'(8'h40 + i); MemD_IO = d; MemRW_IO = 1'b1;
         sb.push_back({AW'(8'h40 + i), d});
         step();
         if (int'(count) > max_cnt) max_cnt = int'(count);
         MemRW_IO = 1'b0; out_ready = 1'b1;
         exp = sb.pop_front();
         total++; if (out_valid !== 1'b1 || {out_addr, out_data} !== exp) begin bad++; $display("FAIL wrap_head%0d: valid=%b got %h/%h expected %h", i, out_valid, out_addr, out_data, exp); end
         step();
         out_ready = 1'b0;
         if (int'(count) > max_cnt) max_cnt = int'(count);
      end
      total++; if (max_cnt > 1) begin bad++; $display("FAIL wrap_max: peak count %0d expected <=1", max_cnt); end
      total++; if (count !== 4'd0) begin bad++; $display("FAIL wrap_end: count got %0d expected 0", count); end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 5; i++) store(AW'(8'h60 + i), DW'(16'h6000 + i), 1'b1);
      #3;
      rst = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_valid: got %b expected 0", out_valid); end
      total++; if (count !== 4'd0) begin bad++; $display("FAIL async_count: got %0d expected 0", count); end
      step();
      rst = 1'b1;
      step();
      sb.delete();
      store(8'h6F, 16'h6F6F, 1'b1);
      drain("async_recover");
   endtask

   task automatic test_reset_release();
      rst = 1'b0; MemRW_IO = 1'b1; trace_en = 1'b1; MemAddr_IO = 8'h55; MemD_IO = 16'h5555;
      step();
      rst = 1'b1;
      step(); step();
      total++; if (count !== 4'd0) begin bad++; $display("FAIL release_nocap: count got %0d expected 0", count); end
      MemRW_IO = 1'b0;
      step();
      sb.delete();
      store(8'h77, 16'h1234, 1'b1);
      total++; if (count !== 4'd1) begin bad++; $display("FAIL release_cap: count got %0d expected 1", count); end
      drain("release_drain");
   endtask

   task automatic test_trace_en_clear();
      do_reset();
      trace_en = 1'b0;
      for (int i = 0; i < 3; i++) store(AW'(8'h80 + i), DW'(16'h8000 + i), 1'b0);
      total++; if (count !== 4'd0) begin bad++; $display("FAIL ten_nocap: count got %0d expected 0", count); end
      trace_en = 1'b1;
      for (int i = 0; i < 4; i++) store(AW'(8'h90 + i), DW'(16'h9000 + i), 1'b1);
      trace_en = 1'b0;
      step();
      total++; if (count !== 4'd4) begin bad++; $display("FAIL ten_keep: count got %0d expected 4", count); end
      clear = 1'b1; step(); clear = 1'b0;
      sb.delete();
      total++; if (count !== 4'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL clear_fifo: count=%0d valid=%b expected 0/0", count, out_valid); end
      trace_en = 1'b1;
      for (int i = 0; i < 10; i++) store(AW'(8'hA0 + i), DW'(16'hA000 + i), 1'b0);
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL clear_pre_ovf: got %b expected 1", overflow); end
      clear = 1'b1; step(); clear = 1'b0;
      total++; if ({count, overflow, drop_cnt} !== 13'd0) begin bad++; $display("FAIL clear_flags: count=%0d ovf=%b drop=%0d expected 0/0/0", count, overflow, drop_cnt); end
      store(8'hB1, 16'hB1B1, 1'b1);
      drain("clear_recover");
   endtask

   initial begin
      test_reset();
      test_single_store();
      test_overflow();
      test_full_push_pop();
      test_wrap();
      test_async_reset();
      test_reset_release();
      test_trace_en_clear();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/mem_store_tracer.md
MEM_STORE_TRACER -- requirements
Module: mem_store_tracer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter ADDR_W, default 8, processor memory address width.
REQ-003 SHALL have parameter DATA_W, default 16, processor memory data width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port MemRW_IO  input  1  processor bus direction; 1 = store.
REQ-007 SHALL have port MemAddr_IO  input  ADDR_W  processor bus address.
REQ-008 SHALL have port MemD_IO  input  DATA_W  processor bus store data.
REQ-009 SHALL have port trace_en  input  1  capture enable.
REQ-010 SHALL have port clear  input  1  synchronous flush of FIFO and flags.
REQ-011 SHALL have port out_valid  output  1  head entry available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-013 SHALL have port out_addr  output  ADDR_W  head entry address.
REQ-014 SHALL have port out_data  output  DATA_W  head entry data.
REQ-015 SHALL have port count  output  clog2(DEPTH)+1  current occupancy.
REQ-016 SHALL have port overflow  output  1  sticky flag: at least one store was dropped.
REQ-017 SHALL have port drop_cnt  output  8  number of dropped stores (see Configuration).

Function
REQ-018 SHALL register MemRW_IO each cycle into rw_q.
REQ-019 SHALL detect a store event in cycle N when MemRW_IO=1, rw_q=0 and trace_en=1; a store held high for several cycles SHALL yield exactly one event.
REQ-020 SHALL record {MemAddr_IO, MemD_IO} as sampled in cycle N.
REQ-021 SHALL write the event into the FIFO at the rising edge closing cycle N; with an empty FIFO, out_valid SHALL be 1 in cycle N+1 (latency 1, no combinational bypass).
REQ-022 SHALL present the oldest entry on out_addr/out_data while out_valid=1; both SHALL hold stable until popped.
REQ-023 SHALL pop the head on a rising edge where out_valid=1 and out_ready=1.
REQ-024 SHALL keep out_addr/out_data at their last value while out_valid=0 (no X).
REQ-025 SHALL drop an event that arrives when count=DEPTH with no pop in the same cycle, and SHALL set overflow.
REQ-026 SHALL accept both operations when an event and a pop occur in the same cycle at count=DEPTH, leaving count unchanged.
REQ-027 SHALL accept both operations when an event and a pop occur in the same cycle at 0<count<DEPTH, leaving count unchanged.
REQ-028 SHALL perform only the push when an event occurs at count=0, since no pop is possible.
REQ-029 SHALL wrap read and write pointers modulo DEPTH.
REQ-030 SHALL evaluate trace_en only at event detection; deasserting it SHALL NOT discard stored entries.
REQ-031 SHALL give clear priority over push and pop: next cycle count=0, out_valid=0, overflow=0 and drop_cnt=0; rw_q keeps tracking.

Reset
REQ-032 SHALL, while rst=0, immediately force rw_q=0, pointers=0, count=0, out_valid=0, out_addr=0, out_data=0, overflow=0 and drop_cnt=0.
REQ-033 SHALL discard all entries when reset is asserted mid-operation.
REQ-034 SHALL NOT capture an event in the first cycle after reset release if MemRW_IO was already 1 during that release; a rising edge is required.

Configuration
REQ-035 SHALL compile the drop counter when macro STORE_TRACE_DROP_CNT_EN is defined: drop_cnt increments once per dropped event and saturates at 255.
REQ-036 SHALL tie drop_cnt to constant 0 when STORE_TRACE_DROP_CNT_EN is undefined; overflow behaviour SHALL be identical in both builds.

Verification
REQ-037 SHALL cover: release rst, pulse MemRW_IO 1 for 3 cycles with addr 0x0D, data 0x0042 -> exactly one entry, out_valid in the next cycle, out_addr=0x0D, out_data=0x0042.
REQ-038 SHALL cover: 10 distinct stores with out_ready=0, DEPTH=8 -> count=8, overflow=1, drop_cnt=2 (macro on) or 0 (macro off); drain returns the first 8 stores in order.
REQ-039 SHALL cover: FIFO full with a store event and out_ready=1 in the same cycle -> count stays 8, new entry kept, overflow stays 0.
REQ-040 SHALL cover: 20 alternating push/pop operations crossing the pointer wrap -> data order preserved and count never exceeds 1.
REQ-041 SHALL cover: 5 entries stored, then rst=0 asynchronously mid-cycle -> out_valid=0 and count=0 before the next clock edge.
REQ-042 SHALL cover: trace_en=0 during 3 stores, then clear with 4 entries held -> no capture during trace_en=0; after clear, count=0, overflow=0 and drop_cnt=0.
